coin_collector: RTL
===================

COIN_COLLECTOR -- requirements
Module: coin_collector

Parameters
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200, giving the number of idle cycles in COLLECT before an automatic refund.

Interface
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have input coin_valid, 1 bit: one-cycle coin-insert strobe.
REQ-005 The block SHALL have input coin_value, 2 bits: 00=1, 01=2, 10=5, 11=invalid coin.
REQ-006 The block SHALL have input select_valid, 1 bit: one-cycle purchase request strobe.
REQ-007 The block SHALL have input select_qty, 4 bits: requested quantity.
REQ-008 The block SHALL have input cancel, 1 bit: customer abort strobe.
REQ-009 The block SHALL have input txn_done, 1 bit: the downstream transaction stage has produced its result.
REQ-010 The block SHALL have input remaining_in, 4 bits: the money returned by the downstream stage.
REQ-011 The block SHALL have output costumer_money, 4 bits: accumulated credit.
REQ-012 The block SHALL have output quantitiy, 4 bits: latched quantity.
REQ-013 The block SHALL have output start, 1 bit: one-cycle transaction launch.
REQ-014 The block SHALL have output coin_reject, 1 bit: one-cycle coin-return pulse.
REQ-015 The block SHALL have output refund_valid, 1 bit: one-cycle refund pulse.
REQ-016 The block SHALL have output refund_amount, 4 bits: the value being refunded.
REQ-017 The block SHALL have output timeout, 1 bit: one-cycle pulse when an auto-refund is triggered.
REQ-018 The block SHALL have output busy, 1 bit: high in every state other than IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, COLLECT, ISSUE, WAIT_RESULT and REFUND.
REQ-020 In IDLE, a valid coin SHALL load credit=value, restart the timer and move the FSM to COLLECT.
REQ-021 In IDLE, select_valid and cancel SHALL be ignored.
REQ-022 In COLLECT, a valid coin SHALL add its value to the credit and restart the timer.
REQ-023 In COLLECT, if credit+value > 15, the coin SHALL be rejected instead: coin_reject pulses and the credit is unchanged; the sum SHALL be computed 5 bits wide.
REQ-024 A coin_value of 11 SHALL pulse coin_reject in any state and SHALL not change the credit.
REQ-025 In every state except IDLE and COLLECT, a coin SHALL pulse coin_reject and SHALL not change the credit.
REQ-026 In COLLECT, select_valid with select_qty != 0 SHALL latch quantitiy and move the FSM to ISSUE; select_qty == 0 SHALL be ignored.
REQ-027 In COLLECT, cancel SHALL move the FSM to REFUND with refund amount = credit.
REQ-028 In COLLECT, when the timer reaches TIMEOUT_CYCLES with no coin, the FSM SHALL pulse timeout and move to REFUND with refund amount = credit.
REQ-029 Same-cycle priority in COLLECT SHALL be: cancel > timeout > select_valid > coin.
REQ-030 In ISSUE, start SHALL be high for exactly one cycle, then the FSM moves to WAIT_RESULT.
REQ-031 costumer_money and quantitiy SHALL be held stable from ISSUE until the FSM returns to IDLE.
REQ-032 In WAIT_RESULT, cancel SHALL be ignored and there SHALL be no timeout.
REQ-033 In WAIT_RESULT, txn_done SHALL latch refund amount = remaining_in (covering both success and the error case where the full credit is returned) and move the FSM to REFUND.
REQ-034 In REFUND, refund_valid SHALL pulse for one cycle only when the amount != 0, with refund_amount valid in that same cycle.
REQ-035 In REFUND, the credit and quantity SHALL then clear to 0 and the FSM moves to IDLE; REFUND SHALL last exactly one cycle.
REQ-036 The latency from select_valid to start SHALL be 1 cycle.
REQ-037 The latency from txn_done to refund_valid SHALL be 1 cycle.
REQ-038 The latency from cancel to refund_valid SHALL be 1 cycle.
REQ-039 refund_amount SHALL be 0 whenever refund_valid is low.

Reset
REQ-040 When rst_n is low, the FSM SHALL enter IDLE immediately, regardless of clk.
REQ-041 When rst_n is low, all outputs SHALL be 0 and the timer cleared.
REQ-042 When rst_n is asserted mid-transaction, the credit SHALL be discarded with no refund pulse.
REQ-043 The first valid edge after rst_n deasserts SHALL be treated as IDLE.

Verification
REQ-044 The bench SHALL cover: coins 5,5,2 then select qty=3 -> costumer_money=12, quantitiy=3, start one cycle later; then txn_done with remaining_in=3 -> refund_valid with refund_amount=3, then IDLE.
REQ-045 The bench SHALL cover: credit 14 plus a coin of 2 -> coin_reject pulse, credit stays 14; a following coin of 1 -> credit 15.
REQ-046 The bench SHALL cover: credit 7 with cancel and select_valid in the same cycle -> refund_amount=7, start never asserted.
REQ-047 The bench SHALL cover: coin of 1 followed by TIMEOUT_CYCLES idle cycles -> timeout and refund_valid with amount 1, busy drops.
REQ-048 The bench SHALL cover: txn_done with remaining_in=0 -> no refund_valid pulse, return to IDLE.
REQ-049 The bench SHALL cover: rst_n low during WAIT_RESULT -> all outputs 0 asynchronously, and a later txn_done is ignored in IDLE.

Source files
------------

// File: rtl/coin_collector.sv
// Coin acceptor front end for a vending transaction: gathers credit, launches a
// purchase, waits for the downstream result and issues a single refund pulse.
module coin_collector #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [3:0] select_qty,
    input  logic       cancel,
    input  logic       txn_done,
    input  logic [3:0] remaining_in,
    output logic [3:0] costumer_money,
    output logic [3:0] quantitiy,
    output logic       start,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [3:0] refund_amount,
    output logic       timeout,
    output logic       busy
);

    localparam int DATA_W  = 4;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_RESULT,
        REFUND
    } state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   credit, credit_nx;
    logic [DATA_W-1:0]   qty, qty_nx;
    logic [DATA_W-1:0]   refund_amt, refund_amt_nx;
    logic [TIMER_W-1:0]  timer, timer_nx;
    logic                coin_reject_nx;
    logic                timeout_nx;
    logic                coin_ok;
    logic [DATA_W-1:0]   coin_amt;
    logic [DATA_W:0]     credit_sum;

    function automatic logic [DATA_W-1:0] coin_worth(input logic [1:0] code);
        case (code)
            2'b00:   return DATA_W'(1);
            2'b01:   return DATA_W'(2);
            2'b10:   return DATA_W'(5);
            default: return '0;
        endcase
    endfunction

    // Five-bit sum so an overflowing coin is detected instead of wrapping.
    function automatic logic [DATA_W:0] add_credit(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign coin_ok    = coin_valid && (coin_value != 2'b11);
    assign coin_amt   = coin_worth(coin_value);
    assign credit_sum = add_credit(credit, coin_amt);

    always_comb begin
        state_nx       = state;
        credit_nx      = credit;
        qty_nx         = qty;
        refund_amt_nx  = refund_amt;
        timer_nx       = timer;
        timeout_nx     = 1'b0;
        coin_reject_nx = coin_valid && (coin_value == 2'b11);

        case (state)
            IDLE: begin
                if (coin_ok) begin
                    credit_nx = coin_amt;
                    timer_nx  = '0;
                    state_nx  = COLLECT;
                end
            end

            // A coin arriving in a cycle taken by a higher-priority event is returned.
            COLLECT: begin
                if (cancel) begin
                    refund_amt_nx  = credit;
                    state_nx       = REFUND;
                    coin_reject_nx = coin_valid;
                end else if (timer == TIMER_LAST) begin
                    timeout_nx     = 1'b1;
                    refund_amt_nx  = credit;
                    state_nx       = REFUND;
                    coin_reject_nx = coin_valid;
                end else if (select_valid && (select_qty != '0)) begin
                    qty_nx         = select_qty;
                    state_nx       = ISSUE;
                    coin_reject_nx = coin_valid;
                end else if (coin_ok && (credit_sum <= (DATA_W+1)'(15))) begin
                    credit_nx = credit_sum[DATA_W-1:0];
                    timer_nx  = '0;
                end else begin
                    coin_reject_nx = coin_valid;
                    timer_nx       = timer + TIMER_W'(1);
                end
            end

            ISSUE: begin
                coin_reject_nx = coin_valid;
                state_nx       = WAIT_RESULT;
            end

            WAIT_RESULT: begin
                coin_reject_nx = coin_valid;
                if (txn_done) begin
                    refund_amt_nx = remaining_in;
                    state_nx      = REFUND;
                end
            end

            REFUND: begin
                coin_reject_nx = coin_valid;
                credit_nx      = '0;
                qty_nx         = '0;
                refund_amt_nx  = '0;
                timer_nx       = '0;
                state_nx       = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            qty         <= '0;
            refund_amt  <= '0;
            timer       <= '0;
            coin_reject <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            qty         <= qty_nx;
            refund_amt  <= refund_amt_nx;
            timer       <= timer_nx;
            coin_reject <= coin_reject_nx;
            timeout     <= timeout_nx;
        end
    end

    // Outputs decoded from registered state so reset clears them without a clock.
    assign costumer_money = credit;
    assign quantitiy      = qty;
    assign start          = (state == ISSUE);
    assign busy           = (state != IDLE);
    assign refund_valid   = (state == REFUND) && (refund_amt != '0);
    assign refund_amount  = refund_valid ? refund_amt : '0;

endmodule
